// File: rtl/key_pkg.sv
// Shared definitions for the key scheduler: FSM state encodings and the
// default WORK timeout.
package key_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'h0,
    ST_WORK = 4'h2,
    ST_DONE = 4'h3
  } state_e;

  localparam logic [31:0] TIMEOUT_DEFAULT = 32'd500_000;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner search: the first set request at or after
// last+1 (modulo N) wins.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   last,
  output logic [2:0]   grant_idx,
  output logic         any
);

  // Rank every requester by its distance from last+1 and keep the closest set one.
  always_comb begin
    int  best;
    int  rank;
    logic hit;
    best      = N;
    rank      = 0;
    hit       = 1'b0;
    grant_idx = 3'd0;
    any       = 1'b0;
    for (int j = 0; j < N; j++) begin
      // 8*N keeps the dividend non-negative for any 3-bit last.
      rank      = (j + 8 * N - 1 - int'(last)) % N;
      hit       = req[j] && (rank < best);
      best      = hit ? rank : best;
      grant_idx = hit ? 3'(j) : grant_idx;
      any       = any | hit;
    end
  end

endmodule

// File: rtl/key_sched.sv
// Key scheduler: arbitrates N key requesters round-robin onto one shared LED
// worker, with a WORK timeout and a saturating timeout counter.
module key_sched
  import key_pkg::*;
#(
  parameter int          N       = 4,
  parameter logic [31:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_fs,
  output logic [N-1:0] req_fd,
  output logic         led_fs,
  output logic [2:0]   led_sel,
  input  logic         led_fd,
  output logic         busy,
  output logic [7:0]   err_cnt
);

  state_e       state_r;
  state_e       state_n_s;
  logic [31:0]  cnt_r;
  logic [7:0]   err_cnt_r;
  logic [2:0]   led_sel_r;
  logic [2:0]   led_sel_n_s;
  logic [2:0]   last_r;
  logic [N-1:0] req_fd_r;
  logic         led_fs_r;
  logic         busy_r;
  logic         timeout_s;
  logic [2:0]   grant_s;
  logic         any_s;
  logic [7:0]   req_pad_s;
  logic [N-1:0] fd_mask_s;

  rr_pick #(.N(N)) u_rr_pick (
    .req       (req_fs),
    .last      (last_r),
    .grant_idx (grant_s),
    .any       (any_s)
  );

  // Widen the request vector so the 3-bit grant index always selects in range.
  always_comb begin
    req_pad_s         = 8'd0;
    req_pad_s[N-1:0]  = req_fs;
  end

  // One-hot done mask for the currently granted key.
  always_comb begin
    fd_mask_s = '0;
    for (int j = 0; j < N; j++) begin
      fd_mask_s[j] = (led_sel_r == 3'(j));
    end
  end

  // Next-state logic; WORK exits by done, then abandonment, then timeout.
  always_comb begin
    state_n_s   = state_r;
    led_sel_n_s = led_sel_r;
    timeout_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (any_s) begin
          state_n_s   = ST_WORK;
          led_sel_n_s = grant_s;
        end else begin
          state_n_s   = ST_IDLE;
        end
      end
      ST_WORK: begin
        if (led_fd) begin
          state_n_s = ST_DONE;
        end else if (!req_pad_s[led_sel_r]) begin
          state_n_s = ST_DONE;
        end else if (cnt_r == (TIMEOUT - 32'd1)) begin
          state_n_s = ST_DONE;
          timeout_s = 1'b1;
        end else begin
          state_n_s = ST_WORK;
        end
      end
      ST_DONE: begin
        state_n_s = ST_IDLE;
      end
      default: begin
        state_n_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 32'd0;
      err_cnt_r <= 8'd0;
      led_sel_r <= 3'd0;
      last_r    <= 3'(N - 1);
      req_fd_r  <= '0;
      led_fs_r  <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_n_s;
      led_sel_r <= led_sel_n_s;
      led_fs_r  <= (state_n_s == ST_WORK);
      busy_r    <= (state_n_s != ST_IDLE);
      if ((state_r == ST_WORK) && (state_n_s == ST_WORK)) begin
        cnt_r <= cnt_r + 32'd1;
      end else begin
        cnt_r <= 32'd0;
      end
      if (timeout_s && (err_cnt_r != 8'hFF)) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end else begin
        err_cnt_r <= err_cnt_r;
      end
      if (state_r == ST_DONE) begin
        last_r <= led_sel_r;
      end else begin
        last_r <= last_r;
      end
      // led_sel is unchanged on WORK->DONE, so the mask already targets the granted key.
      if (state_n_s == ST_DONE) begin
        req_fd_r <= fd_mask_s;
      end else begin
        req_fd_r <= '0;
      end
    end
  end

  assign req_fd  = req_fd_r;
  assign led_fs  = led_fs_r;
  assign led_sel = led_sel_r;
  assign busy    = busy_r;
  assign err_cnt = err_cnt_r;

endmodule

// File: tb/tb_key_sched.sv
// Self-checking bench for key_sched: table of service transactions with a
// grant scoreboard, plus hand-written timeout, tie and reset sequences.
module tb_key_sched;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req_fs;
  logic [N-1:0] req_fd;
  logic         led_fs;
  logic [2:0]   led_sel;
  logic         led_fd;
  logic         busy;
  logic [7:0]   err_cnt;

  int tests;
  int failed;
  logic [2:0] exp_q[$];

  typedef struct {
    logic       do_rst;
    logic [3:0] req;
    logic       drop;
    int         k;
    logic [2:0] sel;
    logic [7:0] err;
  } vec_t;

  vec_t vecs[11];

  key_sched #(.N(N), .TIMEOUT(32'd16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_fs  (req_fs),
    .req_fd  (req_fd),
    .led_fs  (led_fs),
    .led_sel (led_sel),
    .led_fd  (led_fd),
    .busy    (busy),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    req_fs = 4'b0000;
    led_fd = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One full service: request, grant (1-cycle latency), k WORK cycles, exit, DONE, IDLE.
  task automatic serve(input logic [3:0] req, input logic drop, input int k,
                       input logic [2:0] sel, input logic [7:0] err_exp);
    logic [3:0] onehot;
    logic [2:0] want;
    onehot = 4'b0001 << sel;
    req_fs = req;
    exp_q.push_back(sel);
    @(negedge clk);
    check("grant_latency", {31'd0, led_fs}, 32'd1);
    want = exp_q.pop_front();
    check("grant_sel", {29'd0, led_sel}, {29'd0, want});
    for (int i = 1; i < k; i++) begin
      @(negedge clk);
    end
    check("work_fs", {31'd0, led_fs}, 32'd1);
    if (drop) req_fs = req & ~onehot;
    else      led_fd = 1'b1;
    @(negedge clk);
    led_fd = 1'b0;
    check("done_fd", {28'd0, req_fd}, {28'd0, onehot});
    check("done_fs", {31'd0, led_fs}, 32'd0);
    check("done_sel", {29'd0, led_sel}, {29'd0, sel});
    @(negedge clk);
    check("idle_fd", {28'd0, req_fd}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("err_cnt", {24'd0, err_cnt}, {24'd0, err_exp});
  endtask

  initial begin
    int n;
    tests  = 0;
    failed = 0;
    rst_n  = 1'b0;
    req_fs = 4'b0000;
    led_fd = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_fs", {31'd0, led_fs}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fd", {28'd0, req_fd}, 32'd0);
    check("rst_sel", {29'd0, led_sel}, 32'd0);
    check("rst_err", {24'd0, err_cnt}, 32'd0);
    rst_n = 1'b1;

    // led_fd outside WORK is ignored
    @(negedge clk);
    led_fd = 1'b1;
    @(negedge clk);
    led_fd = 1'b0;
    check("stray_fd_busy", {31'd0, busy}, 32'd0);
    check("stray_fd_reqfd", {28'd0, req_fd}, 32'd0);

    //        rst   req      drop  k  sel   err
    vecs[0]  = '{1'b1, 4'b0101, 1'b0, 3, 3'd0, 8'd0};
    vecs[1]  = '{1'b0, 4'b0101, 1'b0, 2, 3'd2, 8'd0};
    vecs[2]  = '{1'b1, 4'b1111, 1'b0, 1, 3'd0, 8'd0};
    vecs[3]  = '{1'b0, 4'b1111, 1'b0, 4, 3'd1, 8'd0};
    vecs[4]  = '{1'b0, 4'b1111, 1'b0, 1, 3'd2, 8'd0};
    vecs[5]  = '{1'b0, 4'b1111, 1'b0, 2, 3'd3, 8'd0};
    vecs[6]  = '{1'b0, 4'b1111, 1'b0, 1, 3'd0, 8'd0};
    vecs[7]  = '{1'b0, 4'b1010, 1'b1, 5, 3'd1, 8'd0};
    vecs[8]  = '{1'b0, 4'b1000, 1'b0, 1, 3'd3, 8'd0};
    vecs[9]  = '{1'b0, 4'b0110, 1'b0, 1, 3'd1, 8'd0};
    vecs[10] = '{1'b0, 4'b0001, 1'b1, 1, 3'd0, 8'd0};

    for (int v = 0; v < 11; v++) begin
      if (vecs[v].do_rst) do_reset();
      serve(vecs[v].req, vecs[v].drop, vecs[v].k, vecs[v].sel, vecs[v].err);
    end

    // Timeout: led_fs high exactly 16 cycles, then done pulse and err_cnt=1
    req_fs = 4'b0100;
    exp_q.push_back(3'd2);
    @(negedge clk);
    n = 0;
    if (led_fs) begin
      check("to_sel", {29'd0, led_sel}, {29'd0, exp_q.pop_front()});
    end else begin
      check("to_grant", {31'd0, led_fs}, 32'd1);
    end
    while (led_fs && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("to_fs_cycles", n, 32'd16);
    check("to_done_fd", {28'd0, req_fd}, 32'h4);
    req_fs = 4'b0000;
    @(negedge clk);
    check("to_err", {24'd0, err_cnt}, 32'd1);

    // led_fd coincides with the last WORK cycle: done wins, err_cnt stays 1
    req_fs = 4'b0100;
    @(negedge clk);
    check("tie_grant", {31'd0, led_fs}, 32'd1);
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
    end
    check("tie_fs_last", {31'd0, led_fs}, 32'd1);
    led_fd = 1'b1;
    @(negedge clk);
    led_fd = 1'b0;
    req_fs = 4'b0000;
    check("tie_done_fd", {28'd0, req_fd}, 32'h4);
    @(negedge clk);
    check("tie_err", {24'd0, err_cnt}, 32'd1);

    // Reset mid-WORK: led_fs drops at once, no done pulse, clean restart
    req_fs = 4'b0010;
    @(negedge clk);
    check("mid_grant", {31'd0, led_fs}, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("mid_fs_async", {31'd0, led_fs}, 32'd0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (req_fd != 4'b0000) n++;
    end
    check("mid_no_fd", n, 32'd0);
    req_fs = 4'b0000;
    rst_n  = 1'b1;
    @(negedge clk);
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_err", {24'd0, err_cnt}, 32'd0);
    check("mid_fd", {28'd0, req_fd}, 32'd0);
    serve(4'b1110, 1'b0, 1, 3'd1, 8'd0);
    req_fs = 4'b0000;

    check("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
